// File: rtl/sampler.sv
// sampler: front-end sampling stage of the logic analyzer.
// Divides clk_i down to the configured sample rate and emits one strobed
// sample of the probe channels per sample period (period = div_q + 1 cycles).
// Optional feature macro: SAMPLER_SYNC_EN -- when defined, d_i passes through
// a two-flop synchronizer before sampling (data latency 3 edges instead of 1).
module sampler #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 24
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             en_i,
    input  logic             cfg_stb_i,
    input  logic [DIV_W-1:0] cfg_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             stb_o,
    output logic [WIDTH-1:0] q_o
);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] cnt_q;
    logic [WIDTH-1:0] src;
    logic             fire;

`ifdef SAMPLER_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Two-stage synchronizer for asynchronous probe inputs
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
        end
    end

    assign src = sync2_q;
`else
    assign src = d_i;
`endif

    // A config write always suppresses the sample and restarts the phase
    assign fire = en_i && !cfg_stb_i && (cnt_q == '0);

    // Divider register, writable regardless of enable
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            div_q <= '0;
        end else if (cfg_stb_i) begin
            div_q <= cfg_i;
        end
    end

    // Down-counter: reloads on terminal count, parked at zero when idle so the
    // first enabled cycle samples immediately
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt_q <= '0;
        end else if (cfg_stb_i || !en_i) begin
            cnt_q <= '0;
        end else if (cnt_q == '0) begin
            cnt_q <= div_q;
        end else begin
            cnt_q <= cnt_q - DIV_W'(1);
        end
    end

    // Sample register and strobe; q_o holds between strobes
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            stb_o <= 1'b0;
            q_o   <= '0;
        end else begin
            stb_o <= fire;
            if (fire) begin
                q_o <= src;
            end
        end
    end

endmodule

// File: tb/tb_sampler.sv
// tb_sampler: self-checking bench for sampler with a sample scoreboard.
module tb_sampler;

    localparam int WIDTH = 4;
    localparam int DIV_W = 24;

    logic             clk_i;
    logic             rst_in;
    logic             en_i;
    logic             cfg_stb_i;
    logic [DIV_W-1:0] cfg_i;
    logic [WIDTH-1:0] d_i;
    logic             stb_o;
    logic [WIDTH-1:0] q_o;

    sampler #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
        .clk_i     (clk_i),
        .rst_in    (rst_in),
        .en_i      (en_i),
        .cfg_stb_i (cfg_stb_i),
        .cfg_i     (cfg_i),
        .d_i       (d_i),
        .stb_o     (stb_o),
        .q_o       (q_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [DIV_W-1:0] m_div = '0;
    logic [DIV_W-1:0] m_cnt = '0;
    logic [WIDTH-1:0] m_s1  = '0;
    logic [WIDTH-1:0] m_s2  = '0;
    logic [WIDTH-1:0] exp_hold = '0;
    logic [WIDTH-1:0] sb_q[$];

    int          cyc;
    logic [31:0] stb_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_div    = '0;
        m_cnt    = '0;
        m_s1     = '0;
        m_s2     = '0;
        exp_hold = '0;
        sb_q.delete();
    endtask

    // One clock: advance model with the inputs the DUT sees, then compare
    task automatic step();
        logic             m_fire;
        logic [WIDTH-1:0] m_src;
        logic [WIDTH-1:0] popped;
        @(posedge clk_i);
        m_fire = en_i && !cfg_stb_i && (m_cnt == '0);
`ifdef SAMPLER_SYNC_EN
        m_src = m_s2;
`else
        m_src = d_i;
`endif
        if (m_fire) sb_q.push_back(m_src);
        if (cfg_stb_i || !en_i) m_cnt = '0;
        else if (m_cnt == '0)   m_cnt = m_div;
        else                    m_cnt--;
        if (cfg_stb_i) m_div = cfg_i;
        m_s2 = m_s1;
        m_s1 = d_i;
        #1;
        chk("stb_o", {31'd0, stb_o}, {31'd0, m_fire});
        if (stb_o) begin
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                popped = sb_q.pop_front();
                chk("q_o", {28'd0, q_o}, {28'd0, popped});
                exp_hold = popped;
            end
            if (cyc < 32) stb_mask |= 32'd1 << cyc;
        end else begin
            chk("q_hold", {28'd0, q_o}, {28'd0, exp_hold});
        end
        cyc++;
    endtask

    task automatic phase_start();
        cyc      = 0;
        stb_mask = '0;
    endtask

    task automatic cfg_write(input logic [DIV_W-1:0] val);
        cfg_stb_i = 1'b1;
        cfg_i     = val;
        step();
        cfg_stb_i = 1'b0;
    endtask

    initial begin
        rst_in    = 1'b0;
        en_i      = 1'b0;
        cfg_stb_i = 1'b0;
        cfg_i     = '0;
        d_i       = 4'hF;
        cyc       = 0;
        stb_mask  = '0;
        model_reset();

        // Reset then idle
        #12;
        chk("rst_stb", {31'd0, stb_o}, 32'd0);
        chk("rst_q", {28'd0, q_o}, 32'd0);
        #1 rst_in = 1'b1;
        phase_start();
        for (int i = 0; i < 10; i++) step();
        chk("idle_mask", stb_mask, 32'd0);
        chk("idle_q", {28'd0, q_o}, 32'd0);

        // Full rate
        cfg_write('0);
        phase_start();
        en_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d_i = WIDTH'(i);
            step();
        end
        chk("full_mask", stb_mask, 32'h0000_0FFF);
        en_i = 1'b0;
        step();

        // Divide by 4
        cfg_write(DIV_W'(3));
        phase_start();
        en_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d_i = WIDTH'(i);
            step();
        end
        chk("div4_mask", stb_mask, 32'h0000_1111);
        en_i = 1'b0;
        step();

        // Reconfig mid-period
        cfg_write(DIV_W'(9));
        phase_start();
        en_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            d_i       = WIDTH'(i + 3);
            cfg_stb_i = (i == 5);
            cfg_i     = DIV_W'(1);
            step();
        end
        cfg_stb_i = 1'b0;
        chk("reconf_mask", stb_mask, 32'h0000_0541);
        en_i = 1'b0;
        step();

        // Enable gap
        cfg_write(DIV_W'(2));
        phase_start();
        for (int i = 0; i < 15; i++) begin
            en_i = !(i >= 4 && i <= 6);
            d_i  = WIDTH'(15 - i);
            step();
        end
        chk("gap_mask", stb_mask, 32'h0000_2489);
        en_i = 1'b0;
        step();

        // Async reset mid-operation
        cfg_write(DIV_W'(5));
        en_i = 1'b1;
        d_i  = 4'hA;
        for (int i = 0; i < 4; i++) step();
        chk("pre_rst_q", {28'd0, q_o}, 32'h0000_000A);
        #2 rst_in = 1'b0;
        #1;
        chk("async_stb", {31'd0, stb_o}, 32'd0);
        chk("async_q", {28'd0, q_o}, 32'd0);
        model_reset();
        #1 rst_in = 1'b1;
        phase_start();
        for (int i = 0; i < 6; i++) begin
            d_i = WIDTH'(i + 1);
            step();
        end
        chk("post_rst_mask", stb_mask, 32'h0000_003F);
        en_i = 1'b0;
        step();

        chk("sb_drained", sb_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
